thumb_fetch: RTL and testbench
==============================

# thumb_fetch

Instruction fetch unit feeding the 16-bit Thumb decoder: it holds the program counter, issues halfword reads to instruction memory over a req/ack interface, buffers returned halfwords in a 2-entry queue and presents them to the decoder under a valid/ready handshake. Branches resolved downstream redirect the PC, flush the queue and discard any in-flight read.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (bit 0 ignored, forced 0)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  read request; once high stays high with mem_addr stable until mem_ack
- mem_addr  out  32  halfword-aligned byte address of the request
- mem_ack  in  1  read completes this cycle; may be high in the same cycle mem_req first rises
- mem_rdata  in  16  read data, valid when mem_ack
- instruction  out  16  queue head, to decoder
- instr_pc  out  32  address of the queue head
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decoder accepts head this cycle
- branch_take  in  1  redirect request, single-cycle pulse
- branch_pc  in  32  address of the branch instruction
- branch_imm  in  11  raw offset field from the branch encoding
- branch_long  in  1  1: 11-bit offset (unconditional form); 0: offset is branch_imm[7:0] (conditional form)

Clock is clk; reset is synchronous and active-high.

## Operation
- State: fetch_pc (next address to request), queue of 2 entries {pc, halfword}, count 0..2, outstanding flag, FSM {RUN, DROP}.
- RUN: if no outstanding request and count <= 1, raise mem_req with mem_addr = fetch_pc. On mem_ack: push {mem_addr, mem_rdata}, fetch_pc += 2, clear outstanding. Outstanding request always has a reserved slot; queue never overflows.
- Pop on instr_valid && instr_ready. Push and pop in one cycle: count unchanged.
- Branch target = branch_pc + 4 + (sext(off) << 1), off = branch_imm (11-bit signed) if branch_long else branch_imm[7:0] (8-bit signed); 32-bit modulo arithmetic, wrap-around allowed, bit 0 forced 0.
- branch_take (highest priority): queue cleared, fetch_pc = target. Any pop in the same cycle is irrelevant (flushed).
  - No request outstanding, or mem_ack in the same cycle: returned data discarded, stay RUN; next request to target issued the following cycle.
  - Request outstanding without mem_ack: go DROP.
- DROP: mem_req held high with the old address (protocol forbids withdrawal); on mem_ack data discarded, return to RUN. instr_valid stays 0. A further branch_take in DROP updates fetch_pc only.
- fetch_pc increments wrap from 32'hFFFF_FFFE to 0.

## Timing
- Reset values: mem_req 0, mem_addr RESET_PC, instruction 0, instr_pc 0, instr_valid 0, FSM RUN, count 0, outstanding 0, fetch_pc RESET_PC. Reset mid-transaction abandons the outstanding read; the memory's late ack after reset, if any, is not this block's concern (memory is reset together).
- First mem_req in the first cycle after reset deasserts.
- mem_req is combinational from state (no dependence on mem_ack in the same cycle).
- Zero-wait memory with instr_ready held high: one instruction per cycle after a 1-cycle fill (ack at edge N -> instr_valid from N+1).
- Branch: instr_valid low the cycle after branch_take; first target instruction visible 1 cycle after its mem_ack (minimum 2 cycles after branch_take with zero-wait memory).
- instruction/instr_pc stable while instr_valid && !instr_ready.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, instructions popped) and perf_flushed (32, branch_take count, plus discarded acks counted separately in perf_dropped, 32); all reset to 0, wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory, instr_ready=1 -> mem_addr 0x100,0x102,0x104 on consecutive cycles; instr_pc follows one cycle later, one instruction per cycle.
- instr_ready=0 for 5 cycles -> exactly 2 instructions queued, mem_req falls, instruction/instr_pc stable; ready restored -> no gap, no duplicate, no loss.
- branch_take, branch_pc=0x200, branch_long=1, branch_imm=11'h7FE (-2) -> next mem_addr 0x200; branch_long=0, branch_imm=0x010 -> 0x224.
- 3-cycle-latency memory, branch_take one cycle after mem_req rises -> mem_req stays on old address until ack, data never appears on instruction, then request to target.
- branch_take same cycle as mem_ack and instr_ready with count=2 -> queue empty next cycle, next mem_addr = target.
- fetch_pc = 0xFFFFFFFE -> next request address 0x00000000.

Source files
------------

// File: rtl/thumb_fetch.sv
// Thumb fetch unit: PC, halfword req/ack reads, 2-entry queue to the decoder; FETCH_PERF_EN adds perf counters.
// Latency: an ack at edge N shows on instruction at N+1; a branch shows its first target instruction 2 cycles later at the earliest.
// Backpressure: instr_ready low fills the queue, then mem_req stops; a read already in flight always has a free slot.
module thumb_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_take,
    input  logic [31:0] branch_pc,
    input  logic [10:0] branch_imm,
    input  logic        branch_long
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_dropped
`endif
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_DROP = 1'b1;

    localparam logic [31:0] START_PC = {RESET_PC[31:1], 1'b0};

    logic        state;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic        outstanding;
    logic [1:0]  count;
    logic [31:0] q0_pc, q1_pc;
    logic [15:0] q0_dat, q1_dat;

    logic        ack;
    logic        pop;
    logic        push;
    logic [10:0] br_off;
    logic [31:0] br_sum;
    logic [31:0] br_target;

    // Once raised, the request is held on the latched address until its ack,
    // even if a branch has moved fetch_pc in the meantime.
    assign mem_req  = !reset && (outstanding || (state == ST_RUN && count <= 2'd1));
    assign mem_addr = outstanding ? req_addr : fetch_pc;

    assign instr_valid = (count != 2'd0);
    assign instruction = q0_dat;
    assign instr_pc    = q0_pc;

    assign ack  = mem_req && mem_ack;
    assign pop  = instr_valid && instr_ready;
    assign push = ack && (state == ST_RUN) && !branch_take;

    assign br_off    = branch_long ? branch_imm : {{3{branch_imm[7]}}, branch_imm[7:0]};
    assign br_sum    = branch_pc + 32'd4 + {{20{br_off[10]}}, br_off, 1'b0};
    assign br_target = {br_sum[31:1], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            fetch_pc    <= START_PC;
            req_addr    <= START_PC;
            outstanding <= 1'b0;
            count       <= 2'd0;
            q0_pc       <= 32'd0;
            q0_dat      <= 16'd0;
            q1_pc       <= 32'd0;
            q1_dat      <= 16'd0;
        end else begin
            outstanding <= mem_req && !mem_ack;
            req_addr    <= mem_addr;

            if (branch_take) begin
                count    <= 2'd0;
                fetch_pc <= br_target;
                state    <= (mem_req && !mem_ack) ? ST_DROP : ST_RUN;
            end else begin
                if (state == ST_DROP) begin
                    if (ack) begin
                        state <= ST_RUN;
                    end
                end else if (ack) begin
                    fetch_pc <= fetch_pc + 32'd2;
                end

                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            q0_pc  <= mem_addr;
                            q0_dat <= mem_rdata;
                        end else begin
                            q1_pc  <= mem_addr;
                            q1_dat <= mem_rdata;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        q0_pc  <= q1_pc;
                        q0_dat <= q1_dat;
                        count  <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            q0_pc  <= mem_addr;
                            q0_dat <= mem_rdata;
                        end else begin
                            q0_pc  <= q1_pc;
                            q0_dat <= q1_dat;
                            q1_pc  <= mem_addr;
                            q1_dat <= mem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Acks discarded either in DROP or coincident with a redirect count as dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_flushed <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            if (pop && !branch_take) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (branch_take) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
            if (ack && (state == ST_DROP || branch_take)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_thumb_fetch.sv
// Bench for thumb_fetch: behavioural memory with programmable latency and an expected-instruction queue.
module tb_thumb_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_take = 1'b0;
    logic [31:0] branch_pc = 32'd0;
    logic [10:0] branch_imm = 11'd0;
    logic        branch_long = 1'b0;

    thumb_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch_take (branch_take),
        .branch_pc   (branch_pc),
        .branch_imm  (branch_imm),
        .branch_long (branch_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] dat;
    } ent_t;

    ent_t        sb_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic        n_reset = 1'b1, n_ready = 1'b0, n_br = 1'b0, n_long = 1'b0;
    logic [31:0] n_bpc = 32'd0;
    logic [10:0] n_bimm = 11'd0;

    int          lat = 0;
    int          age = 0;
    logic [31:0] exp_fetch = 32'h100;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic        prev_br = 1'b0;
    logic        last_start = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    function automatic logic [31:0] calc_target(input logic [31:0] pc, input logic [10:0] imm, input logic lng);
        int          off;
        logic [7:0]  low;
        low = imm[7:0];
        if (lng) off = (int'(imm) >= 1024) ? int'(imm) - 2048 : int'(imm);
        else     off = (int'(low) >= 128) ? int'(low) - 256 : int'(low);
        return (pc + 32'd4 + 32'(off * 2)) & 32'hFFFF_FFFE;
    endfunction

    // One clock: drive staged inputs at negedge, model memory, update and check the scoreboard.
    task automatic cycle();
        ent_t e;
        @(negedge clk);
        reset       = n_reset;
        instr_ready = n_ready;
        branch_take = n_br;
        branch_pc   = n_bpc;
        branch_imm  = n_bimm;
        branch_long = n_long;
        #1;
        if (prev_hold) begin
            check_val("req_hold", {31'd0, mem_req}, 32'd1);
            check_val("addr_hold", mem_addr, prev_addr);
        end
        if (prev_br) check_val("valid_after_branch", {31'd0, instr_valid}, 32'd0);
        last_start = mem_req && (age == 0);
        if (mem_req) begin
            if (age >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                age       = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                age++;
            end
        end else begin
            mem_ack = 1'b0;
            age     = 0;
        end
        prev_hold = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_br   = branch_take;
        if (reset) begin
            sb_q.delete();
            exp_fetch = 32'h100;
        end else if (branch_take) begin
            sb_q.delete();
            exp_fetch = calc_target(branch_pc, branch_imm, branch_long);
        end else begin
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_valid", {31'd0, instr_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("instr_pc", instr_pc, e.pc);
                    check_val("instruction", {16'd0, instruction}, {16'd0, e.dat});
                end
            end
            if (mem_ack && mem_addr == exp_fetch) begin
                sb_q.push_back(ent_t'{pc: exp_fetch, dat: mem_word(exp_fetch)});
                exp_fetch = exp_fetch + 32'd2;
            end
        end
    endtask

    task automatic do_branch(input logic [31:0] pc, input logic [10:0] imm, input logic lng);
        n_br = 1'b1; n_bpc = pc; n_bimm = imm; n_long = lng;
        cycle();
        n_br = 1'b0;
    endtask

    logic [31:0] br_pc_tab [3] = '{32'h200, 32'h200, 32'h200};
    logic [10:0] br_imm_tab[3] = '{11'h7FE, 11'h010, 11'h3F0};
    logic        br_lng_tab[3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] br_exp_tab[3] = '{32'h200, 32'h224, 32'h1E4};

    initial begin
        logic        got;
        logic [31:0] old_addr;

        // Reset state
        n_reset = 1'b1;
        repeat (3) cycle();
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'h100);
        check_val("rst_instruction", {16'd0, instruction}, 32'd0);
        check_val("rst_instr_pc", instr_pc, 32'd0);
        check_val("rst_instr_valid", {31'd0, instr_valid}, 32'd0);

        // Zero-wait streaming from RESET_PC
        n_reset = 1'b0; n_ready = 1'b1;
        cycle();
        check_val("first_req", {31'd0, mem_req}, 32'd1);
        check_val("addr0", mem_addr, 32'h100);
        check_val("valid0", {31'd0, instr_valid}, 32'd0);
        cycle();
        check_val("addr1", mem_addr, 32'h102);
        check_val("valid1", {31'd0, instr_valid}, 32'd1);
        check_val("pc1", instr_pc, 32'h100);
        cycle();
        check_val("addr2", mem_addr, 32'h104);
        check_val("pc2", instr_pc, 32'h102);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("stream_valid", {31'd0, instr_valid}, 32'd1);
        end

        // Decoder stall: queue fills to two, request stops, head stable
        n_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i > 0) begin
                check_val("stall_req", {31'd0, mem_req}, 32'd0);
                check_val("stall_valid", {31'd0, instr_valid}, 32'd1);
                check_val("stall_depth", sb_q.size(), 32'd2);
                if (sb_q.size() > 0) begin
                    check_val("stall_pc", instr_pc, sb_q[0].pc);
                    check_val("stall_instr", {16'd0, instruction}, {16'd0, sb_q[0].dat});
                end
            end
        end
        n_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("resume_valid", {31'd0, instr_valid}, 32'd1);
        end

        // Branch target arithmetic with zero-wait memory
        for (int b = 0; b < 3; b++) begin
            do_branch(br_pc_tab[b], br_imm_tab[b], br_lng_tab[b]);
            cycle();
            check_val("br_req", {31'd0, mem_req}, 32'd1);
            check_val("br_addr", mem_addr, br_exp_tab[b]);
            cycle();
            check_val("br_first_valid", {31'd0, instr_valid}, 32'd1);
            check_val("br_first_pc", instr_pc, br_exp_tab[b]);
            repeat (2) cycle();
        end

        // Branch with a full queue
        n_ready = 1'b0;
        repeat (3) cycle();
        check_val("full_req", {31'd0, mem_req}, 32'd0);
        n_ready = 1'b1;
        do_branch(32'h500, 11'h002, 1'b1);
        cycle();
        check_val("full_br_addr", mem_addr, 32'h508);
        check_val("full_br_req", {31'd0, mem_req}, 32'd1);
        repeat (3) cycle();

        // 3-cycle memory: branch during an outstanding read, re-branch in DROP
        lat = 3;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            got = last_start;
        end
        if (!got) check_val("req_start_timeout", {31'd0, got}, 32'd1);
        do_branch(32'h300, 11'h010, 1'b1);
        old_addr = mem_addr;
        do_branch(32'h3FC, 11'h000, 1'b1);
        check_val("drop_addr_rebranch", mem_addr, old_addr);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            check_val("drop_valid", {31'd0, instr_valid}, 32'd0);
            check_val("drop_addr", mem_addr, old_addr);
            got = mem_ack;
        end
        if (!got) check_val("drop_ack_timeout", {31'd0, got}, 32'd1);
        cycle();
        check_val("after_drop_req", {31'd0, mem_req}, 32'd1);
        check_val("after_drop_addr", mem_addr, 32'h400);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = instr_valid;
        end
        check_val("after_drop_pc", instr_pc, 32'h400);
        repeat (8) cycle();

        // Address wrap at the top of the address space
        lat = 0;
        repeat (2) cycle();
        do_branch(32'hFFFF_FFFC, 11'h7FF, 1'b1);
        cycle();
        check_val("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
        cycle();
        check_val("wrap_addr1", mem_addr, 32'h0000_0000);
        check_val("wrap_pc", instr_pc, 32'hFFFF_FFFE);
        cycle();
        check_val("wrap_addr2", mem_addr, 32'h0000_0002);
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
